mc_ctrl: RTL

Multi-cycle control unit for the MIPS-subset CPU: a Moore-style state machine that sequences fetch, decode, execute, memory and write-back for each instruction over 3–5 cycles, driving the datapath mux selects and write enables. It sits beside the datapath, reads `op`/`func` from the registered instruction register, and talks to a single unified memory port through a `mem_req`/`mem_ready` handshake. Compared with the single-decode controller, it adds wait-state tolerant memory access, illegal-opcode trapping, a retired-instruction counter and an optional bus timeout.

---
 rtl/mc_ctrl_if.sv | 20 ++
 rtl/mc_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - unified memory port between the multi-cycle controller and memory
//
// Purpose: groups the single memory request/response handshake.
// Signals:
//    mem_req    - controller requests a memory access this cycle
//    mem_we     - the request is a write
//    i_or_d     - address select: 0 PC (instruction), 1 ALUOut (data)
//    mem_ready  - memory completes the current request this cycle
// Modports:
//    master - controller side (drives request, samples ready)
//    slave  - memory side
interface mc_ctrl_if;
   logic mem_req;
   logic mem_we;
   logic i_or_d;
   logic mem_ready;

   modport master (output mem_req, output mem_we, output i_or_d, input mem_ready);
   modport slave  (input mem_req, input mem_we, input i_or_d, output mem_ready);
endinterface

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS-subset control unit
//
// Purpose: Moore-style sequencer for fetch/decode/execute/memory/write-back,
// driving datapath mux selects and write strobes, with illegal-opcode trap,
// retired-instruction counter and optional memory bus timeout.
// Optional feature macro: MC_CTRL_TIMEOUT_EN (bus timeout to BUSERR state).
// Parameters:
//    CNT_W           - width of retired-instruction counter
//    TIMEOUT_CYCLES  - wait cycles tolerated per memory request (1..255)
// Ports:
//    clk, rst_n      - clock, asynchronous active-low reset
//    op, func        - opcode and R-type function from the instruction register
//    memBus          - memory handshake (mc_ctrl_if master)
//    reg_dst, ext_op, mem_to_reg, alu_op, alu_src_a, alu_src_b, pc_src - mux selects
//    pc_write, pc_write_cond, ir_write, reg_write - datapath strobes
//    illegal, bus_err      - sticky trap flags
//    instr_retired         - pulse on last cycle of each instruction
//    retired_cnt           - retired instruction count (wraps)
//    state                 - current state for debug
module mc_ctrl #(
   parameter int CNT_W          = 32,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       op,
   input  logic [5:0]       func,
   mc_ctrl_if.master        memBus,
   output logic [1:0]       reg_dst,
   output logic [1:0]       ext_op,
   output logic [1:0]       mem_to_reg,
   output logic [1:0]       alu_op,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       pc_src,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             ir_write,
   output logic             reg_write,
   output logic             illegal,
   output logic             bus_err,
   output logic             instr_retired,
   output logic [CNT_W-1:0] retired_cnt,
   output logic [3:0]       state
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MADDR   = 4'd2,
      MREAD   = 4'd3,
      MWB     = 4'd4,
      MWRITE  = 4'd5,
      REXE    = 4'd6,
      RWB     = 4'd7,
      IEXE    = 4'd8,
      IWB     = 4'd9,
      BRANCH  = 4'd10,
      JUMP    = 4'd11,
      JR      = 4'd12,
      ILLEGAL = 4'd13,
      BUSERR  = 4'd14
   } stateT;

   stateT            stateQ, nextState;
   logic [CNT_W-1:0] retiredCntQ;
   logic             illegalQ;
   logic [7:0]       waitCnt;
   logic             timeoutHit;

   // raw strobes, gated by rst_n before leaving the block
   logic memReqRaw, memWeRaw, pcWriteRaw, pcWriteCondRaw, irWriteRaw, regWriteRaw;
   logic retiredRaw;

   logic isRtype, isAddu, isSubu, isJr;

   assign isRtype = (op == OP_RTYPE);
   assign isAddu  = isRtype && (func == FN_ADDU);
   assign isSubu  = isRtype && (func == FN_SUBU);
   assign isJr    = isRtype && (func == FN_JR);

   // waitCnt is 0 whenever the timeout feature is compiled out, so this never fires
   assign timeoutHit = (waitCnt >= TIMEOUT_LIMIT);

   always_comb begin
      nextState      = stateQ;
      memReqRaw      = 1'b0;
      memWeRaw       = 1'b0;
      memBus.i_or_d  = 1'b0;
      pcWriteRaw     = 1'b0;
      pcWriteCondRaw = 1'b0;
      irWriteRaw     = 1'b0;
      regWriteRaw    = 1'b0;
      reg_dst        = 2'b00;
      ext_op         = 2'b00;
      mem_to_reg     = 2'b00;
      alu_op         = 2'b00;
      alu_src_a      = 1'b0;
      alu_src_b      = 2'b00;
      pc_src         = 2'b00;

      case (stateQ)
         FETCH: begin
            memReqRaw = 1'b1;
            alu_src_b = 2'b01;
            if (memBus.mem_ready) begin
               irWriteRaw = 1'b1;
               pcWriteRaw = 1'b1;
               nextState  = DECODE;
            end else if (timeoutHit) begin
               nextState = BUSERR;
            end
         end
         DECODE: begin
            alu_src_b = 2'b11;   // branch target precomputed into ALUOut
            if (op == OP_LW || op == OP_SW)                           nextState = MADDR;
            else if (isAddu || isSubu)                                nextState = REXE;
            else if (op == OP_ORI || op == OP_LUI || op == OP_ADDIU)  nextState = IEXE;
            else if (op == OP_BEQ)                                    nextState = BRANCH;
            else if (op == OP_J || op == OP_JAL)                      nextState = JUMP;
            else if (isJr)                                            nextState = JR;
            else                                                      nextState = ILLEGAL;
         end
         MADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            ext_op    = 2'b01;
            nextState = (op == OP_LW) ? MREAD : MWRITE;
         end
         MREAD: begin
            memReqRaw     = 1'b1;
            memBus.i_or_d = 1'b1;
            if (memBus.mem_ready) nextState = MWB;
            else if (timeoutHit)  nextState = BUSERR;
         end
         MWB: begin
            regWriteRaw = 1'b1;
            mem_to_reg  = 2'b01;
            nextState   = FETCH;
         end
         MWRITE: begin
            memReqRaw     = 1'b1;
            memWeRaw      = 1'b1;
            memBus.i_or_d = 1'b1;
            if (memBus.mem_ready) nextState = FETCH;
            else if (timeoutHit)  nextState = BUSERR;
         end
         REXE: begin
            alu_src_a = 1'b1;
            alu_op    = isSubu ? 2'b01 : 2'b00;
            nextState = RWB;
         end
         RWB: begin
            regWriteRaw = 1'b1;
            reg_dst     = 2'b01;
            nextState   = FETCH;
         end
         IEXE: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            if (op == OP_ORI) begin
               ext_op = 2'b00;
               alu_op = 2'b10;
            end else if (op == OP_LUI) begin
               ext_op = 2'b10;   // rs is $0, so or-ing yields imm<<16
               alu_op = 2'b10;
            end else begin
               ext_op = 2'b01;
               alu_op = 2'b00;
            end
            nextState = IWB;
         end
         IWB: begin
            regWriteRaw = 1'b1;
            nextState   = FETCH;
         end
         BRANCH: begin
            alu_src_a      = 1'b1;
            alu_op         = 2'b01;
            pcWriteCondRaw = 1'b1;
            pc_src         = 2'b01;
            nextState      = FETCH;
         end
         JUMP: begin
            pcWriteRaw = 1'b1;
            pc_src     = 2'b10;
            if (op == OP_JAL) begin
               regWriteRaw = 1'b1;
               reg_dst     = 2'b10;
               mem_to_reg  = 2'b10;
            end
            nextState = FETCH;
         end
         JR: begin
            pcWriteRaw = 1'b1;
            pc_src     = 2'b11;
            nextState  = FETCH;
         end
         ILLEGAL: nextState = ILLEGAL;
         BUSERR:  nextState = BUSERR;
         default: nextState = FETCH;
      endcase

      retiredRaw = (nextState == FETCH) && (stateQ != FETCH);
   end

   assign memBus.mem_req = memReqRaw      & rst_n;
   assign memBus.mem_we  = memWeRaw       & rst_n;
   assign pc_write       = pcWriteRaw     & rst_n;
   assign pc_write_cond  = pcWriteCondRaw & rst_n;
   assign ir_write       = irWriteRaw     & rst_n;
   assign reg_write      = regWriteRaw    & rst_n;
   assign instr_retired  = retiredRaw     & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ      <= FETCH;
         retiredCntQ <= '0;
         illegalQ    <= 1'b0;
      end else begin
         stateQ <= nextState;
         if (retiredRaw) retiredCntQ <= retiredCntQ + CNT_W'(1);
         if (nextState == ILLEGAL) illegalQ <= 1'b1;
      end
   end

`ifdef MC_CTRL_TIMEOUT_EN
   logic busErrQ;

   // counts consecutive wait cycles of the current request; any completed
   // request or non-request cycle starts the next request from zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         waitCnt <= 8'd0;
         busErrQ <= 1'b0;
      end else begin
         if (memReqRaw && !memBus.mem_ready) waitCnt <= waitCnt + 8'd1;
         else                                waitCnt <= 8'd0;
         if (nextState == BUSERR) busErrQ <= 1'b1;
      end
   end

   assign bus_err = busErrQ;
`else
   assign waitCnt = 8'd0;
   assign bus_err = 1'b0;
`endif

   assign illegal     = illegalQ;
   assign retired_cnt = retiredCntQ;
   assign state       = stateQ;

endmodule
